elevator_request_scheduler: RTL and testbench

- Latches hall-call and cab-panel requests, owns the request lamps, and chooses the next target floor using a LOOK (directional sweep) policy.
- Hands each target to the elevator motion FSM through a hold-until-arrived handshake, then times the door dwell at each stop.
- Sits between the debounced button inputs and the elevator FSM, replacing ad-hoc floor selection.

---
 rtl/elevator_request_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_elevator_request_scheduler.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_request_scheduler.sv
// elevator_request_scheduler
//
// Latches hall-call and cab-panel requests into sticky lamp registers and picks
// the next target floor with a LOOK (directional sweep) policy. It then hands
// the target to the motion FSM and holds activate high until arrival. Finally
// it times the door dwell at each serviced stop.
//
// Ports:
//   clock          system clock, rising-edge active
//   reset          asynchronous, active-high reset
//   call_req       debounced hall-call buttons (level, one bit per floor)
//   panel_req      debounced cab destination buttons (level, one bit per floor)
//   current_floor  car position reported by the motion FSM
//   arrived        one-cycle pulse from the FSM when the car stopped at target
//   emergency      emergency stop (level)
//   power_on       main power switch (level)
//   target_floor   floor dispatched to the FSM
//   direction_up   sweep direction, 1 = up, 0 = down
//   activate       dispatch valid, held until arrival
//   door_hold      high while the door dwell runs
//   call_lights    latched pending hall calls
//   panel_lights   latched pending cab requests
//   sched_idle     high when idle with nothing pending
module elevator_request_scheduler #(
    parameter int NUM_FLOORS   = 11,
    parameter int FLOOR_BITS   = 4,
    parameter int DWELL_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [NUM_FLOORS-1:0] panel_req,
    input  logic [FLOOR_BITS-1:0] current_floor,
    input  logic                  arrived,
    input  logic                  emergency,
    input  logic                  power_on,
    output logic [FLOOR_BITS-1:0] target_floor,
    output logic                  direction_up,
    output logic                  activate,
    output logic                  door_hold,
    output logic [NUM_FLOORS-1:0] call_lights,
    output logic [NUM_FLOORS-1:0] panel_lights,
    output logic                  sched_idle
);

    localparam int CNT_W = $clog2(DWELL_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_MOVING,
        ST_DWELL,
        ST_HALT
    } state_t;

    state_t                  state_q, state_d;
    logic [FLOOR_BITS-1:0]   target_q, target_d;
    logic                    dir_up_q, dir_up_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [NUM_FLOORS-1:0]   call_q, call_d;
    logic [NUM_FLOORS-1:0]   panel_q, panel_d;

    logic [NUM_FLOORS-1:0]   pending;
    logic [NUM_FLOORS-1:0]   here_mask;
    logic [NUM_FLOORS-1:0]   clear_mask;
    logic [NUM_FLOORS-1:0]   call_set;
    logic [NUM_FLOORS-1:0]   panel_set;
    logic [FLOOR_BITS-1:0]   up_floor;
    logic [FLOOR_BITS-1:0]   down_floor;
    logic                    up_found;
    logic                    down_found;
    logic                    pending_here;
    logic                    press_here;
    logic                    halt_cond;

    assign pending      = call_q | panel_q;
    assign pending_here = |(pending & here_mask);
    assign press_here   = |((call_req | panel_req) & here_mask);
    assign halt_cond    = emergency | ~power_on;

    // Floor search. here_mask stays all-zero when current_floor is out of range.
    // In that case nothing counts as "at the current floor", and the searches
    // below still find the nearest pending floor on either side.
    // The up search keeps the lowest hit above the car.
    // The down search keeps the highest hit below the car.
    always_comb begin
        here_mask  = '0;
        up_floor   = '0;
        up_found   = 1'b0;
        down_floor = '0;
        down_found = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            here_mask[i] = (current_floor == FLOOR_BITS'(i));
        end
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (FLOOR_BITS'(i) > current_floor)) begin
                up_found = 1'b1;
                up_floor = FLOOR_BITS'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (FLOOR_BITS'(i) < current_floor)) begin
                down_found = 1'b1;
                down_floor = FLOOR_BITS'(i);
            end
        end
    end

    // Next state, dispatch and lamp update. Halt overrides everything, and a
    // dispatched target is never changed until the car reports arrival there.
    // Clears are applied after sets, so a service clear always wins.
    // Loss of power wipes all lamps regardless of state.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        dir_up_d   = dir_up_q;
        count_d    = count_q;
        clear_mask = '0;
        call_set   = call_req;
        panel_set  = panel_req;

        if (halt_cond) begin
            state_d = ST_HALT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|pending) begin
                        state_d = ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (!(|pending)) begin
                        state_d = ST_IDLE;
                    end else if (pending_here) begin
                        clear_mask = here_mask;
                        count_d    = CNT_W'(DWELL_CYCLES);
                        state_d    = ST_DWELL;
                    end else if (dir_up_q ? up_found : down_found) begin
                        target_d = dir_up_q ? up_floor : down_floor;
                        state_d  = ST_MOVING;
                    end else begin
                        // Nothing ahead: reverse the sweep.
                        dir_up_d = ~dir_up_q;
                        target_d = dir_up_q ? down_floor : up_floor;
                        state_d  = ST_MOVING;
                    end
                end
                ST_MOVING: begin
                    if (arrived && (current_floor == target_q)) begin
                        clear_mask = here_mask;
                        count_d    = CNT_W'(DWELL_CYCLES);
                        state_d    = ST_DWELL;
                    end
                end
                ST_DWELL: begin
                    // A press for the open floor extends the dwell instead of
                    // becoming a new request.
                    if (press_here) begin
                        call_set  = call_req & ~here_mask;
                        panel_set = panel_req & ~here_mask;
                        count_d   = CNT_W'(DWELL_CYCLES);
                    end else if (count_q == CNT_W'(1)) begin
                        state_d = ST_SELECT;
                    end else begin
                        count_d = count_q - CNT_W'(1);
                    end
                end
                ST_HALT: begin
                    state_d = (|pending) ? ST_SELECT : ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        call_d  = (call_q | call_set) & ~clear_mask;
        panel_d = (panel_q | panel_set) & ~clear_mask;
        if (!power_on) begin
            call_d  = '0;
            panel_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
            dir_up_q <= 1'b1;
            count_q  <= '0;
            call_q   <= '0;
            panel_q  <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            dir_up_q <= dir_up_d;
            count_q  <= count_d;
            call_q   <= call_d;
            panel_q  <= panel_d;
        end
    end

    assign target_floor = target_q;
    assign direction_up = dir_up_q;
    assign activate     = (state_q == ST_MOVING);
    assign door_hold    = (state_q == ST_DWELL);
    assign call_lights  = call_q;
    assign panel_lights = panel_q;
    assign sched_idle   = (state_q == ST_IDLE) && !(|pending);

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Testbench for elevator_request_scheduler.
// A behavioural LOOK model predicts the ordered list of stop events
// (dispatches and door dwells) for each batch of presses. It pushes them into a
// scoreboard queue. A monitor pops and compares whenever activate or door_hold
// rises. A car process plays the motion FSM, including stray arrived pulses.
module tb_elevator_request_scheduler;

    localparam int NF = 11;
    localparam int FB = 4;
    localparam int DW = 16;
    localparam logic [NF-1:0] ONE = NF'(1);

    logic          clock = 1'b0;
    logic          reset;
    logic [NF-1:0] call_req;
    logic [NF-1:0] panel_req;
    logic [FB-1:0] current_floor;
    logic          arrived;
    logic          emergency;
    logic          power_on;
    logic [FB-1:0] target_floor;
    logic          direction_up;
    logic          activate;
    logic          door_hold;
    logic [NF-1:0] call_lights;
    logic [NF-1:0] panel_lights;
    logic          sched_idle;

    typedef struct {
        bit is_door;
        int floor;
        bit dir;
        int len;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  car_floor = 0;
    bit  model_dir = 1'b1;

    assign current_floor = FB'(car_floor);

    always #5 clock = ~clock;

    elevator_request_scheduler #(
        .NUM_FLOORS(NF), .FLOOR_BITS(FB), .DWELL_CYCLES(DW)
    ) dut (
        .clock(clock), .reset(reset), .call_req(call_req), .panel_req(panel_req),
        .current_floor(current_floor), .arrived(arrived), .emergency(emergency),
        .power_on(power_on), .target_floor(target_floor), .direction_up(direction_up),
        .activate(activate), .door_hold(door_hold), .call_lights(call_lights),
        .panel_lights(panel_lights), .sched_idle(sched_idle)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic logic [NF-1:0] bitOf(input int f);
        return ONE << f;
    endfunction

    // Nearest pending floor strictly beyond 'floor' in direction 'dir'.
    function automatic void nearest(input logic [NF-1:0] pend, input int floor, input bit dir,
                                    output int t, output bit found);
        t = 0;
        found = 1'b0;
        if (dir) begin
            for (int i = 0; i < NF; i++) begin
                if ((pend & bitOf(i)) != '0 && i > floor) begin
                    t = i; found = 1'b1; break;
                end
            end
        end else begin
            for (int i = NF - 1; i >= 0; i--) begin
                if ((pend & bitOf(i)) != '0 && i < floor) begin
                    t = i; found = 1'b1; break;
                end
            end
        end
    endfunction

    task automatic pushEvent(input bit is_door, input int floor, input bit dir, input int len);
        ev_t e;
        e.is_door = is_door;
        e.floor = floor;
        e.dir = dir;
        e.len = len;
        exp_q.push_back(e);
    endtask

    // LOOK sweep over a fixed request set: service the car's floor first,
    // otherwise go to the nearest request ahead, reversing when nothing is ahead.
    task automatic predictFrom(input logic [NF-1:0] pend_in, input int floor_in,
                               input bit dir_in, output bit dir_out);
        logic [NF-1:0] pend = pend_in;
        int floor = floor_in;
        bit dir = dir_in;
        int t;
        bit found;
        while (pend != '0) begin
            if ((pend & bitOf(floor)) != '0) begin
                pushEvent(1'b1, floor, dir, DW);
                pend &= ~bitOf(floor);
            end else begin
                nearest(pend, floor, dir, t, found);
                if (!found) begin
                    dir = !dir;
                    nearest(pend, floor, dir, t, found);
                end
                if (!found) break;
                pushEvent(1'b0, t, dir, 0);
                pushEvent(1'b1, t, dir, DW);
                pend &= ~bitOf(t);
                floor = t;
            end
        end
        dir_out = dir;
    endtask

    // Presses 'mask' for one cycle, split randomly over hall and cab buttons
    // (some floors on both).
    task automatic applyStimulus(input logic [NF-1:0] mask, output logic [NF-1:0] c,
                                 output logic [NF-1:0] p);
        logic [NF-1:0] r1 = NF'($urandom);
        logic [NF-1:0] r2 = NF'($urandom);
        c = mask & r1;
        p = (mask & ~r1) | (mask & r1 & r2);
        call_req = c;
        panel_req = p;
        tick(1);
        call_req = '0;
        panel_req = '0;
    endtask

    task automatic recoverReset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        model_dir = 1'b1;
        tick(1);
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (!(exp_q.size() == 0 && sched_idle && !door_hold && !activate) && n < budget) begin
            tick(1);
            n++;
        end
        if (n >= budget) begin
            checks++;
            failures++;
            $display("[TB] FAIL episode_timeout: %0d events outstanding, expected 0", exp_q.size());
            exp_q.delete();
            recoverReset();
        end else begin
            checkOutput("idle_lights", int'(call_lights | panel_lights), 0);
            checkOutput("idle_dir", int'(direction_up), int'(model_dir));
        end
    endtask

    // mode 0: plain batch; 1: second batch mid-trip; 2: emergency mid-trip;
    // 3: async reset mid-trip. Modes 1-3 require 'a' to exclude the car floor.
    task automatic runEpisode(input logic [NF-1:0] a, input logic [NF-1:0] b, input int mode);
        logic [NF-1:0] c, p, c2, p2;
        int t;
        bit found, d, nd;
        if (mode == 0) begin
            predictFrom(a, car_floor, model_dir, nd);
            applyStimulus(a, c, p);
            checkOutput("latch_call", int'(call_lights), int'(c));
            checkOutput("latch_panel", int'(panel_lights), int'(p));
            model_dir = nd;
            waitDone(3000);
            return;
        end
        d = model_dir;
        nearest(a, car_floor, d, t, found);
        if (!found) begin
            d = !d;
            nearest(a, car_floor, d, t, found);
        end
        pushEvent(1'b0, t, d, 0);
        applyStimulus(a, c, p);
        checkOutput("latch_call", int'(call_lights), int'(c));
        checkOutput("latch_panel", int'(panel_lights), int'(p));
        tick(1);
        checkOutput("activate_early", int'(activate), 0);
        tick(1);
        checkOutput("activate_latency", int'(activate), 1);
        if (mode == 3) begin
            reset = 1'b1;
            #1;
            checkOutput("rst_activate", int'(activate), 0);
            checkOutput("rst_lights", int'(call_lights | panel_lights), 0);
            checkOutput("rst_target", int'(target_floor), 0);
            checkOutput("rst_dir", int'(direction_up), 1);
            checkOutput("rst_sched_idle", int'(sched_idle), 1);
            exp_q.delete();
            tick(1);
            reset = 1'b0;
            model_dir = 1'b1;
            tick(2);
            checkOutput("post_rst_idle", int'(sched_idle), 1);
            return;
        end
        if (mode == 2) begin
            emergency = 1'b1;
            tick(1);
            checkOutput("emerg_activate", int'(activate), 0);
            checkOutput("emerg_lights", int'(call_lights | panel_lights), int'(a));
            tick(3);
            emergency = 1'b0;
            pushEvent(1'b0, t, d, 0);
            b = '0;
        end else begin
            applyStimulus(b, c2, p2);
        end
        pushEvent(1'b1, t, d, DW);
        predictFrom((a | b) & ~bitOf(t), t, d, nd);
        model_dir = nd;
        waitDone(3000);
    endtask

    // Door reload: press the open floor n negedges after the door opens.
    task automatic dwellReload(input int floor, input int n);
        logic [NF-1:0] c, p;
        int k = 0;
        car_floor = floor;
        pushEvent(1'b1, floor, model_dir, n + 1 + DW);
        applyStimulus(bitOf(floor), c, p);
        while (!door_hold && k < 20) begin
            tick(1);
            k++;
        end
        tick(n);
        call_req = bitOf(floor);
        tick(1);
        call_req = '0;
        checkOutput("dwell_press_not_latched", int'(call_lights), 0);
        waitDone(3000);
    endtask

    task automatic powerLoss();
        logic [NF-1:0] c, p;
        car_floor = 0;
        applyStimulus(NF'(11'h0A4), c, p);
        checkOutput("pwr_lights_before", int'(call_lights | panel_lights), 'h0A4);
        power_on = 1'b0;
        tick(1);
        checkOutput("pwr_lights_cleared", int'(call_lights | panel_lights), 0);
        checkOutput("pwr_activate", int'(activate), 0);
        checkOutput("pwr_sched_idle", int'(sched_idle), 0);
        for (int i = 0; i < 4; i++) begin
            call_req = NF'($urandom);
            panel_req = NF'($urandom);
            tick(1);
            checkOutput("pwr_press_ignored", int'(call_lights | panel_lights), 0);
        end
        call_req = '0;
        panel_req = '0;
        power_on = 1'b1;
        tick(2);
        checkOutput("pwr_restore_idle", int'(sched_idle), 1);
        waitDone(100);
    endtask

    // Scoreboard monitor.
    initial begin
        bit  prev_act = 1'b0;
        bit  prev_door = 1'b0;
        bit  tracked = 1'b0;
        int  door_len = 0;
        int  want_len = 0;
        ev_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_act = 1'b0;
                prev_door = 1'b0;
                tracked = 1'b0;
                continue;
            end
            if (activate && !prev_act) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_dispatch: target %0d, expected no dispatch", target_floor);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("event_kind", 0, int'(e.is_door));
                    if (!e.is_door) begin
                        checkOutput("dispatch_target", int'(target_floor), e.floor);
                        checkOutput("dispatch_dir", int'(direction_up), int'(e.dir));
                    end
                end
            end
            if (door_hold && !prev_door) begin
                door_len = 1;
                tracked = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_door: at floor %0d, expected no door", car_floor);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("event_kind", 1, int'(e.is_door));
                    checkOutput("door_lights_clear",
                                int'(((call_lights | panel_lights) & bitOf(car_floor)) != '0), 0);
                    tracked = e.is_door;
                    want_len = e.len;
                end
            end else if (door_hold) begin
                door_len++;
            end
            if (!door_hold && prev_door && tracked) begin
                checkOutput("door_length", door_len, want_len);
            end
            prev_act = activate;
            prev_door = door_hold;
        end
    end

    // Car model: after a random travel time it reports arrival at the target.
    // Sometimes it sends a stray arrived pulse at the wrong floor first.
    initial begin
        int d;
        bit ok;
        bit spur;
        arrived = 1'b0;
        forever begin
            @(negedge clock);
            arrived = 1'b0;
            if (activate && !reset) begin
                d = $urandom_range(3, 7);
                spur = 1'($urandom_range(0, 1));
                ok = 1'b1;
                for (int k = 0; k < d; k++) begin
                    @(negedge clock);
                    arrived = (k == 0) && spur;
                    if (!activate) begin
                        ok = 1'b0;
                        arrived = 1'b0;
                        break;
                    end
                end
                if (ok) begin
                    car_floor = int'(target_floor);
                    arrived = 1'b1;
                end
            end
        end
    end

    // Main stimulus sequence.
    initial begin
        logic [NF-1:0] a;
        logic [NF-1:0] b;
        int mode;
        reset = 1'b1;
        call_req = '0;
        panel_req = '0;
        emergency = 1'b0;
        power_on = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        checkOutput("reset_target", int'(target_floor), 0);
        checkOutput("reset_dir", int'(direction_up), 1);
        checkOutput("reset_activate", int'(activate), 0);
        checkOutput("reset_door", int'(door_hold), 0);
        checkOutput("reset_lights", int'(call_lights | panel_lights), 0);
        checkOutput("reset_sched_idle", int'(sched_idle), 1);

        car_floor = 0;
        runEpisode(bitOf(5), '0, 1);
        car_floor = 4;
        runEpisode(bitOf(8), bitOf(2) | bitOf(6), 1);
        runEpisode(bitOf(4), '0, 1);
        car_floor = 10;
        runEpisode(bitOf(3), '0, 0);
        dwellReload(7, DW - 3);
        car_floor = 2;
        runEpisode(bitOf(9), '0, 2);
        powerLoss();
        car_floor = 1;
        runEpisode(bitOf(6) | bitOf(9), '0, 3);
        car_floor = 12;
        runEpisode(bitOf(3) | bitOf(7), '0, 0);

        for (int ep = 0; ep < 20; ep++) begin
            mode = $urandom_range(0, 2);
            a = NF'($urandom_range(1, 2047)) & NF'($urandom_range(1, 2047));
            if (mode != 0) a &= ~bitOf(car_floor);
            if (a == '0) a = bitOf((car_floor + 1) % NF);
            b = (mode == 1) ? (NF'($urandom) & NF'($urandom)) : '0;
            runEpisode(a, b, mode);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
